// File: rtl/shared_adder_arb_pkg.sv
// Shared types and helpers for the shared-adder arbiter (FSM state encoding, ID width helper).
package shared_adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  // ID width never collapses to zero, even for degenerate requester counts.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_adder_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after ptr, wrapping.
module rr_arbiter
  import shared_adder_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_adder_arb.sv
// One registered adder shared round-robin among N_REQ requesters, results tagged by ID.
// Define SHARED_ADDER_ARB_SAT_EN to saturate the sum to DATA_WIDTH bits on carry-out.
module shared_adder_arb
  import shared_adder_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int N_REQ      = 4,
  localparam int ID_W       = clog2_min1(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_WIDTH:0]         res_sum,
  output logic [ID_W-1:0]             res_id,
  output logic                        busy
);

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       ptr_reg, id_reg, grant_idx;
  logic [N_REQ-1:0]      grant_onehot;
  logic [DATA_WIDTH-1:0] a_reg, b_reg;
  logic [DATA_WIDTH:0]   sum_reg, sum_next, full_sum;
  logic [DATA_WIDTH-1:0] a_sl [N_REQ];
  logic [DATA_WIDTH-1:0] b_sl [N_REQ];
  logic                  take;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_sl[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_sl[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req          (req_valid),
    .ptr          (ptr_reg),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  // The arbiter only grants asserted requests, so a grant in IDLE is a handshake.
  assign take = (state_reg == IDLE) && (|grant_onehot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (take) state_next = ADD;
      ADD:     state_next = RESP;
      RESP:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        req_ready = rst_n ? grant_onehot : '0;
        busy      = 1'b0;
      end
      RESP:    res_valid = 1'b1;
      default: ;
    endcase
  end

  assign full_sum = {1'b0, a_reg} + {1'b0, b_reg};

`ifdef SHARED_ADDER_ARB_SAT_EN
  assign sum_next = full_sum[DATA_WIDTH] ? {1'b0, {DATA_WIDTH{1'b1}}} : full_sum;
`else
  assign sum_next = full_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= ID_W'(N_REQ - 1);
      id_reg  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
    end else begin
      if (take) begin
        a_reg   <= a_sl[grant_idx];
        b_reg   <= b_sl[grant_idx];
        id_reg  <= grant_idx;
        ptr_reg <= grant_idx;
      end
      if (state_reg == ADD) sum_reg <= sum_next;
    end
  end

  assign res_sum = sum_reg;
  assign res_id  = id_reg;

endmodule
